// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer: sizes, tag/index types and the
// logical layout of one ROB entry.
package reorder_buffer_pkg;

    localparam int ROB_WIDTH = 4;                 // tag width, log2 of entry count
    localparam int REG_WIDTH = 5;                 // architectural register index width
    localparam int ROB_SIZE  = 1 << ROB_WIDTH;    // number of entries

    typedef logic [ROB_WIDTH-1:0] robTag_t;
    typedef logic [REG_WIDTH-1:0] regIdx_t;
    typedef logic [ROB_WIDTH:0]   robCount_t;     // one extra bit so "16 in flight" is representable

    // Logical view of one entry, assembled from the per-field storage arrays
    typedef struct packed {
        logic        valid;
        logic        ready;
        logic        branch;
        logic        predict;
        logic        taken;
        regIdx_t     rd;
        logic [31:0] data;
        logic [31:0] pc;
    } robEntry_t;

    // Circular pointer advance; the natural ROB_WIDTH-bit overflow is the wrap
    function automatic robTag_t tagInc(robTag_t t);
        return robTag_t'(t + 1'b1);
    endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Issue / CDB / operand-query / commit / flush signals of the reorder buffer.
// slave = the ROB itself, master = the surrounding pipeline (or a bench).
interface reorder_buffer_if;
    import reorder_buffer_pkg::*;

    // issue
    logic        issueFlag;
    regIdx_t     issueReg;
    logic        issueBranch;
    logic        issuePredict;
    robTag_t     issueROB;
    logic        full;
    // common data bus writeback
    logic        cdbFlag;
    robTag_t     cdbROB;
    logic [31:0] cdbData;
    logic        cdbTaken;
    logic [31:0] cdbPC;
    // operand lookups from rename
    robTag_t     qry1ROB;
    robTag_t     qry2ROB;
    logic        qry1Ready;
    logic        qry2Ready;
    logic [31:0] qry1Data;
    logic [31:0] qry2Data;
    // commit to the register file
    logic        writeFlag;
    robTag_t     writeSrc;
    regIdx_t     writeReg;
    logic [31:0] writeData;
    // mispredict flush
    logic        clrOut;
    logic [31:0] clrPC;

    modport master (
        output issueFlag, issueReg, issueBranch, issuePredict,
        output cdbFlag, cdbROB, cdbData, cdbTaken, cdbPC,
        output qry1ROB, qry2ROB,
        input  issueROB, full,
        input  qry1Ready, qry2Ready, qry1Data, qry2Data,
        input  writeFlag, writeSrc, writeReg, writeData,
        input  clrOut, clrPC
    );

    modport slave (
        input  issueFlag, issueReg, issueBranch, issuePredict,
        input  cdbFlag, cdbROB, cdbData, cdbTaken, cdbPC,
        input  qry1ROB, qry2ROB,
        output issueROB, full,
        output qry1Ready, qry2Ready, qry1Data, qry2Data,
        output writeFlag, writeSrc, writeReg, writeData,
        output clrOut, clrPC
    );

endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order commit queue. Allocates a tag per issued instruction,
// captures CDB results, retires one entry per cycle into the register file
// write port and flushes everything on a mispredicted branch.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic            clkIn,
    input  logic            rstIn,
    input  logic            rdyIn,
    reorder_buffer_if.slave bus
);

    robTag_t             head;
    robTag_t             tail;
    robCount_t           count;
    logic [ROB_SIZE-1:0] validBits;
    logic [ROB_SIZE-1:0] readyBits;

    // Payload storage; valid/ready gate every use, so these need no reset
    logic        branchArr  [ROB_SIZE];
    logic        predictArr [ROB_SIZE];
    logic        takenArr   [ROB_SIZE];
    regIdx_t     regArr     [ROB_SIZE];
    logic [31:0] dataArr    [ROB_SIZE];
    logic [31:0] pcArr      [ROB_SIZE];

    robEntry_t   headEntry;
    logic        commitNow;
    logic        flushNow;
    logic        issueAccept;
    logic        wbAccept;
    logic        qry1Hit;
    logic        qry2Hit;

    logic        writeFlagReg;
    robTag_t     writeSrcReg;
    regIdx_t     writeRegReg;
    logic [31:0] writeDataReg;
    logic        clrOutReg;
    logic [31:0] clrPCReg;

    // Assemble the head entry from the per-field arrays
    always_comb begin
        headEntry         = '0;
        headEntry.valid   = validBits[head];
        headEntry.ready   = readyBits[head];
        headEntry.branch  = branchArr[head];
        headEntry.predict = predictArr[head];
        headEntry.taken   = takenArr[head];
        headEntry.rd      = regArr[head];
        headEntry.data    = dataArr[head];
        headEntry.pc      = pcArr[head];
    end

    // Retire needs the result captured on an earlier edge, so a CDB write
    // never races the entry being retired. A flush outranks a same-cycle issue,
    // and issue stays blocked while the flush pulse is still out.
    assign commitNow   = rdyIn && headEntry.valid && headEntry.ready;
    assign flushNow    = commitNow && headEntry.branch && (headEntry.taken != headEntry.predict);
    assign bus.full    = (count == robCount_t'(ROB_SIZE));
    assign issueAccept = rdyIn && bus.issueFlag && !bus.full && !clrOutReg && !flushNow;
    assign wbAccept    = rdyIn && bus.cdbFlag && validBits[bus.cdbROB];
    assign bus.issueROB = tail;

    genvar gi;
    generate
        for (gi = 0; gi < ROB_SIZE; gi++) begin : gEntry
            logic validQ;
            logic readyQ;
            logic issueHit;
            logic wbHit;
            logic retireHit;

            assign issueHit  = issueAccept && (tail == robTag_t'(gi));
            assign wbHit     = wbAccept && (bus.cdbROB == robTag_t'(gi));
            assign retireHit = commitNow && (head == robTag_t'(gi));

            // Occupancy and result-ready tracking for this slot
            always_ff @(posedge clkIn or negedge rstIn) begin
                if (!rstIn) begin
                    validQ <= 1'b0;
                    readyQ <= 1'b0;
                end else if (flushNow) begin
                    validQ <= 1'b0;
                    readyQ <= 1'b0;
                end else begin
                    if (retireHit)
                        validQ <= 1'b0;
                    else if (issueHit)
                        validQ <= 1'b1;
                    if (issueHit)
                        readyQ <= 1'b0;
                    else if (wbHit)
                        readyQ <= 1'b1;
                end
            end

            assign validBits[gi] = validQ;
            assign readyBits[gi] = readyQ;
        end
    endgenerate

    // Capture issue-time fields at the tail and CDB results at the tagged slot
    always_ff @(posedge clkIn) begin
        if (issueAccept) begin
            regArr[tail]     <= bus.issueReg;
            branchArr[tail]  <= bus.issueBranch;
            predictArr[tail] <= bus.issuePredict;
        end
        if (wbAccept) begin
            dataArr[bus.cdbROB]  <= bus.cdbData;
            takenArr[bus.cdbROB] <= bus.cdbTaken;
            pcArr[bus.cdbROB]    <= bus.cdbPC;
        end
    end

    // Head/tail pointers and occupancy; full/empty are judged from count only
    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flushNow) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (commitNow)
                head <= tagInc(head);
            if (issueAccept)
                tail <= tagInc(tail);
            count <= count + robCount_t'(issueAccept) - robCount_t'(commitNow);
        end
    end

    // Registered commit and flush pulses; payloads hold between pulses
    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            writeFlagReg <= 1'b0;
            writeSrcReg  <= '0;
            writeRegReg  <= '0;
            writeDataReg <= '0;
            clrOutReg    <= 1'b0;
            clrPCReg     <= '0;
        end else begin
            writeFlagReg <= commitNow && !headEntry.branch;
            clrOutReg    <= flushNow;
            if (commitNow && !headEntry.branch) begin
                writeSrcReg  <= head;
                writeRegReg  <= headEntry.rd;
                writeDataReg <= headEntry.data;
            end
            if (flushNow)
                clrPCReg <= headEntry.pc;
        end
    end

    assign bus.writeFlag = writeFlagReg;
    assign bus.writeSrc  = writeSrcReg;
    assign bus.writeReg  = writeRegReg;
    assign bus.writeData = writeDataReg;
    assign bus.clrOut    = clrOutReg;
    assign bus.clrPC     = clrPCReg;

    // Operand lookups: stored result, or the value on the CDB this very cycle
    assign qry1Hit       = bus.cdbFlag && (bus.cdbROB == bus.qry1ROB);
    assign qry2Hit       = bus.cdbFlag && (bus.cdbROB == bus.qry2ROB);
    assign bus.qry1Ready = (validBits[bus.qry1ROB] && readyBits[bus.qry1ROB]) || qry1Hit;
    assign bus.qry2Ready = (validBits[bus.qry2ROB] && readyBits[bus.qry2ROB]) || qry2Hit;
    assign bus.qry1Data  = qry1Hit ? bus.cdbData : dataArr[bus.qry1ROB];
    assign bus.qry2Data  = qry2Hit ? bus.cdbData : dataArr[bus.qry2ROB];

endmodule
